rob_cdb_sink: RTL
=================

Name: rob_cdb_sink

Overview:
- Reorder buffer that sits at the receiving end of the common data bus (CDB).
- Allocates one entry per issued instruction and captures the result when the CDB broadcasts the entry's tag.
- Retires entries in program order to the register file.
- Also serves operand lookups from the issue stage for results that have completed but not yet committed.

Parameters:
data_width, 16, width of the result value carried on the CDB
tag_width, 3, width of the CDB tag; entry count = 2**tag_width (8 by default), tag = entry index

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush (mispredict); clears all entries
issue_valid  input  1  request to allocate an entry this cycle
issue_dr  input  3  destination register of the issuing instruction
issue_regwrite  input  1  instruction writes issue_dr at commit
issue_tag  output  tag_width  tag allocated on a successful issue (current tail)
full  output  1  no free entry; issue is refused
CDB_in  input  1+tag_width+data_width  CDB struct: valid, tag, data
rd_tag_a, rd_tag_b  input  tag_width  operand lookup tags
rd_ready_a, rd_ready_b  output  1  looked-up entry holds a valid result
rd_value_a, rd_value_b  output  data_width  looked-up result
commit_valid  output  1  head entry retires this cycle
commit_tag  output  tag_width  tag of the retiring entry
commit_dr  output  3  destination register of the retiring entry
commit_regwrite  output  1  register file write enable for the retiring entry
commit_data  output  data_width  value to write

Behaviour:
- Entry state: busy, ready, dr, regwrite, value.
- Pointers: head, tail (tag_width bits, wrap modulo 2**tag_width); count (tag_width+1 bits).
- Reset (async, rst_n=0): all busy=0, ready=0; head=tail=count=0; value=0.
  - Resulting outputs: full=0, commit_valid=0, issue_tag=0, rd_ready_*=0, all data outputs 0.
- full = (count == 2**tag_width), combinational.
- issue_tag = tail, combinational.
- Issue: if issue_valid && !full:
  - entry[tail] gets busy=1, ready=0, dr, regwrite;
  - tail++ and count++ on the edge.
- Issue while full is ignored, even if a commit occurs in the same cycle.
- CDB capture: if CDB_in.valid && busy[CDB_in.tag]:
  - ready=1, value=data on the edge.
- CDB_in.valid to a non-busy tag is ignored; no state change.
- A repeated CDB write to an already-ready entry overwrites value.
- Commit, combinational:
  - commit_valid = busy[head] && ready[head];
  - commit_tag/dr/regwrite/data are driven from entry[head].
- When commit_valid=1, on the edge: busy[head]=0, ready=0, head++, count--.
- Only one commit per cycle.
- Latency: a CDB result for the head entry appears on commit_valid one cycle after the broadcast.
- Issue and commit in the same cycle: count is unchanged; both pointers advance.
- The allocation tag never equals a busy tag, so issue and CDB never collide on one entry.
- Lookup ports: rd_ready_x = busy[rd_tag_x] && ready[rd_tag_x]; rd_value_x = value[rd_tag_x]; combinational.
- Flush (synchronous): next state equals the reset state.
  - Flush overrides issue, CDB capture and commit in that cycle.
  - commit_valid is still driven combinationally during the flush cycle.
  - The consumer must qualify commit_valid with !flush.
- Async reset asserted mid-operation discards all entries immediately.

Optional Feature:
ROB_RD_FWD_EN:
- Defined: lookup ports forward the current cycle's CDB.
  - If CDB_in.valid && CDB_in.tag==rd_tag_x && busy[rd_tag_x], then rd_ready_x=1 and rd_value_x=CDB_in.data in the same cycle.
- Undefined: lookups reflect stored state only; the broadcast result is visible one cycle later.

Test Plan:
- Reset, then issue 8 instructions (issue_dr=0..7) with no CDB -> issue_tag 0..7, full=1 after the 8th edge; a 9th issue is ignored and tail stays 0.
- Issue tags 0,1; CDB tag1 data 16'h1234, then tag0 data 16'hBEEF -> commit_valid only after tag0 is captured; commits tag0 (16'hBEEF), then tag1 (16'h1234) on consecutive cycles.
- CDB valid with tag 5 while entry 5 is not busy -> no state change; rd_ready for tag 5 stays 0; no commit.
- Fill to full, make the head ready, then assert issue_valid during the commit cycle -> commit occurs, issue refused; next cycle full=0 and issue accepted at tag 0 (wrap).
- With 4 busy entries, 2 of them ready, assert flush together with issue_valid and a CDB write -> next cycle count=0, head=tail=0, commit_valid=0, all rd_ready=0.
- Issue tag 2, CDB tag 2 data 16'h00A5 with rd_tag_a=2 in the same cycle -> rd_ready_a=1 and 16'h00A5 that cycle with ROB_RD_FWD_EN; without the macro it stays 0 that cycle and becomes 1 the next.

Source files
------------

// File: rtl/rob_cdb_sink.sv
// rtl/rob_cdb_sink.sv - reorder buffer capturing CDB results and retiring in program order
// Optional macro ROB_RD_FWD_EN: lookup ports also forward the current cycle's CDB broadcast.
module rob_cdb_sink #(
    parameter int data_width = 16,
    parameter int tag_width  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            issue_valid,
    input  logic [2:0]                      issue_dr,
    input  logic                            issue_regwrite,
    output logic [tag_width-1:0]            issue_tag,
    output logic                            full,
    input  logic [tag_width+data_width:0]   CDB_in,
    input  logic [tag_width-1:0]            rd_tag_a,
    input  logic [tag_width-1:0]            rd_tag_b,
    output logic                            rd_ready_a,
    output logic                            rd_ready_b,
    output logic [data_width-1:0]           rd_value_a,
    output logic [data_width-1:0]           rd_value_b,
    output logic                            commit_valid,
    output logic [tag_width-1:0]            commit_tag,
    output logic [2:0]                      commit_dr,
    output logic                            commit_regwrite,
    output logic [data_width-1:0]           commit_data
);

    localparam int unsigned depth = 2 ** tag_width;
    localparam logic [tag_width:0] full_count = depth[tag_width:0];

    logic                  busy_q     [depth];
    logic                  ready_q    [depth];
    logic [2:0]            dr_q       [depth];
    logic                  regwrite_q [depth];
    logic [data_width-1:0] value_q    [depth];

    logic [tag_width-1:0]  head_q, head_d;
    logic [tag_width-1:0]  tail_q, tail_d;
    logic [tag_width:0]    count_q, count_d;

    logic                  cdb_valid;
    logic [tag_width-1:0]  cdb_tag;
    logic [data_width-1:0] cdb_data;
    logic                  issue_fire;

    assign cdb_valid = CDB_in[tag_width+data_width];
    assign cdb_tag   = CDB_in[tag_width+data_width-1:data_width];
    assign cdb_data  = CDB_in[data_width-1:0];

    assign full       = (count_q == full_count);
    assign issue_tag  = tail_q;
    assign issue_fire = issue_valid && !full;

    assign commit_valid    = busy_q[head_q] && ready_q[head_q];
    assign commit_tag      = head_q;
    assign commit_dr       = dr_q[head_q];
    assign commit_regwrite = regwrite_q[head_q];
    assign commit_data     = value_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (issue_fire) begin
            tail_d = tail_q + 1'b1;
        end
        if (commit_valid) begin
            head_d = head_q + 1'b1;
        end
        if (issue_fire && !commit_valid) begin
            count_d = count_q + 1'b1;
        end else if (!issue_fire && commit_valid) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        rd_ready_a = busy_q[rd_tag_a] && ready_q[rd_tag_a];
        rd_ready_b = busy_q[rd_tag_b] && ready_q[rd_tag_b];
        rd_value_a = value_q[rd_tag_a];
        rd_value_b = value_q[rd_tag_b];
`ifdef ROB_RD_FWD_EN
        if (cdb_valid && cdb_tag == rd_tag_a && busy_q[rd_tag_a]) begin
            rd_ready_a = 1'b1;
            rd_value_a = cdb_data;
        end
        if (cdb_valid && cdb_tag == rd_tag_b && busy_q[rd_tag_b]) begin
            rd_ready_b = 1'b1;
            rd_value_b = cdb_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                busy_q[i]     <= 1'b0;
                ready_q[i]    <= 1'b0;
                dr_q[i]       <= '0;
                regwrite_q[i] <= 1'b0;
                value_q[i]    <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < depth; i++) begin
                busy_q[i]     <= 1'b0;
                ready_q[i]    <= 1'b0;
                dr_q[i]       <= '0;
                regwrite_q[i] <= 1'b0;
                value_q[i]    <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue_fire) begin
                busy_q[tail_q]     <= 1'b1;
                ready_q[tail_q]    <= 1'b0;
                dr_q[tail_q]       <= issue_dr;
                regwrite_q[tail_q] <= issue_regwrite;
            end
            if (cdb_valid && busy_q[cdb_tag]) begin
                ready_q[cdb_tag] <= 1'b1;
                value_q[cdb_tag] <= cdb_data;
            end
            // Retirement wins over a same-cycle CDB write to the head entry.
            if (commit_valid) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
